// File: rtl/c432_seq_pkg.sv
// Shared types and default constants for the c432 vector sequencer.
// Holds the sequencer state enumeration and the default MISR polynomial and seed.
package c432_seq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        APPLY   = 3'd2,
        SETTLE  = 3'd3,
        CAPTURE = 3'd4,
        DONE    = 3'd5
    } seq_state_e;

    localparam logic [15:0] DEF_SIG_POLY = 16'h1021;
    localparam logic [15:0] DEF_SIG_SEED = 16'hFFFF;

endpackage

// File: rtl/seq_misr.sv
// Multiple-input signature register: Galois-style shift with polynomial feedback.
// load restarts from SEED; enable folds one data word into the running signature.
import c432_seq_pkg::*;

module seq_misr #(
    parameter int                 WIDTH = 16,
    parameter logic [WIDTH-1:0]   POLY  = WIDTH'(DEF_SIG_POLY),
    parameter logic [WIDTH-1:0]   SEED  = WIDTH'(DEF_SIG_SEED)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] signature
);

    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] sig_next;

    always_comb begin
        sig_next = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= SEED;
        end else if (load) begin
            sig_q <= SEED;
        end else if (enable) begin
            sig_q <= sig_next;
        end
    end

    assign signature = sig_q;

endmodule

// File: rtl/c432_vector_sequencer.sv
// Fetches vectors from memory, applies them to the CUT, waits, captures and signs the outputs.
// Optional golden-response comparison is compiled in with `define SEQ_GOLDEN_CMP_EN.
import c432_seq_pkg::*;

module c432_vector_sequencer #(
    parameter int                    VEC_WIDTH    = 36,
    parameter int                    OUT_WIDTH    = 7,
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    SETTLE_WIDTH = 8,
    parameter int                    SIG_WIDTH    = 16,
    parameter logic [SIG_WIDTH-1:0]  SIG_POLY     = SIG_WIDTH'(DEF_SIG_POLY),
    parameter logic [SIG_WIDTH-1:0]  SIG_SEED     = SIG_WIDTH'(DEF_SIG_SEED)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [ADDR_WIDTH-1:0]   vec_count,
    input  logic [SETTLE_WIDTH-1:0] settle_cycles,
    output logic                    mem_rd_en,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [VEC_WIDTH-1:0]    mem_rdata,
    output logic [VEC_WIDTH-1:0]    cut_in,
    input  logic [OUT_WIDTH-1:0]    cut_out,
    output logic                    cap_valid,
    output logic [OUT_WIDTH-1:0]    cap_data,
    output logic [ADDR_WIDTH-1:0]   cap_idx,
    output logic                    busy,
    output logic                    done,
    output logic [SIG_WIDTH-1:0]    signature
`ifdef SEQ_GOLDEN_CMP_EN
    ,
    input  logic [OUT_WIDTH-1:0]    gold_rdata,
    output logic [ADDR_WIDTH-1:0]   mismatch_cnt,
    output logic                    fail_seen,
    output logic [ADDR_WIDTH-1:0]   first_fail_idx
`endif
);

    localparam logic [2:0] ST_IDLE    = IDLE;
    localparam logic [2:0] ST_FETCH   = FETCH;
    localparam logic [2:0] ST_APPLY   = APPLY;
    localparam logic [2:0] ST_SETTLE  = SETTLE;
    localparam logic [2:0] ST_CAPTURE = CAPTURE;
    localparam logic [2:0] ST_DONE    = DONE;

    logic [2:0]              state;
    logic [ADDR_WIDTH-1:0]   idx;
    logic [ADDR_WIDTH-1:0]   vec_count_q;
    logic [SETTLE_WIDTH-1:0] settle_q;
    logic [SETTLE_WIDTH-1:0] settle_cnt;

    logic launch;
    logic capture_en;
    logic last_vec;

    // abort outranks every transition, including a start seen in IDLE
    assign launch     = (state == ST_IDLE) && start && !abort;
    assign capture_en = (state == ST_CAPTURE) && !abort;
    assign last_vec   = (idx == vec_count_q - ADDR_WIDTH'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            idx         <= '0;
            vec_count_q <= '0;
            settle_q    <= '0;
            settle_cnt  <= '0;
            cut_in      <= '0;
            cap_data    <= '0;
            cap_idx     <= '0;
            cap_valid   <= 1'b0;
        end else begin
            cap_valid <= 1'b0;
            if (abort) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            vec_count_q <= vec_count;
                            settle_q    <= settle_cycles;
                            idx         <= '0;
                            state       <= (vec_count == '0) ? ST_DONE : ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        state <= ST_APPLY;
                    end
                    ST_APPLY: begin
                        cut_in     <= mem_rdata;
                        settle_cnt <= settle_q;
                        state      <= (settle_q != '0) ? ST_SETTLE : ST_CAPTURE;
                    end
                    ST_SETTLE: begin
                        settle_cnt <= settle_cnt - SETTLE_WIDTH'(1);
                        if (settle_cnt == SETTLE_WIDTH'(1)) begin
                            state <= ST_CAPTURE;
                        end
                    end
                    ST_CAPTURE: begin
                        cap_data  <= cut_out;
                        cap_idx   <= idx;
                        cap_valid <= 1'b1;
                        if (last_vec) begin
                            state <= ST_DONE;
                        end else begin
                            idx   <= idx + ADDR_WIDTH'(1);
                            state <= ST_FETCH;
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // memory returns the word one cycle after the strobe, i.e. during APPLY
    assign mem_rd_en = (state == ST_FETCH);
    assign mem_addr  = idx;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

    seq_misr #(
        .WIDTH (SIG_WIDTH),
        .POLY  (SIG_POLY),
        .SEED  (SIG_SEED)
    ) u_misr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (launch),
        .enable    (capture_en),
        .data      (SIG_WIDTH'(cut_out)),
        .signature (signature)
    );

`ifdef SEQ_GOLDEN_CMP_EN
    logic [OUT_WIDTH-1:0] gold_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gold_q         <= '0;
            mismatch_cnt   <= '0;
            fail_seen      <= 1'b0;
            first_fail_idx <= '0;
        end else if (launch) begin
            gold_q         <= '0;
            mismatch_cnt   <= '0;
            fail_seen      <= 1'b0;
            first_fail_idx <= '0;
        end else if ((state == ST_APPLY) && !abort) begin
            gold_q <= gold_rdata;
        end else if (capture_en && (cut_out != gold_q)) begin
            if (mismatch_cnt != '1) begin
                mismatch_cnt <= mismatch_cnt + ADDR_WIDTH'(1);
            end
            if (!fail_seen) begin
                fail_seen      <= 1'b1;
                first_fail_idx <= idx;
            end
        end
    end
`else
    // golden comparison not built: no extra ports, no compare state
`endif

endmodule

// File: tb/tb_c432_vector_sequencer.sv
// Directed plus randomized bench for c432_vector_sequencer with a behavioural CUT/ROM model.
// Timing, capture stream and signature are predicted from the run parameters alone.
module tb_c432_vector_sequencer;

    localparam int VW = 36;
    localparam int OW = 7;
    localparam int AW = 16;
    localparam int SW = 8;
    localparam int GW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] vec_count = '0;
    logic [SW-1:0] settle_cycles = '0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [VW-1:0] mem_rdata = '0;
    logic [VW-1:0] cut_in;
    logic [OW-1:0] cut_out;
    logic          cap_valid;
    logic [OW-1:0] cap_data;
    logic [AW-1:0] cap_idx;
    logic          busy;
    logic          done;
    logic [GW-1:0] signature;

    logic [VW-1:0] mem [64];
    logic          cut_mode = 1'b1;
    logic [OW-1:0] cut_force = '0;
    logic [OW-1:0] exp_q [$];
    int            pass_cnt = 0;
    int            total_cnt = 0;

    c432_vector_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .vec_count     (vec_count),
        .settle_cycles (settle_cycles),
        .mem_rd_en     (mem_rd_en),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .cut_in        (cut_in),
        .cut_out       (cut_out),
        .cap_valid     (cap_valid),
        .cap_data      (cap_data),
        .cap_idx       (cap_idx),
        .busy          (busy),
        .done          (done),
        .signature     (signature)
    );

    // clock / reset
    always #5 clk = ~clk;

    // synchronous vector ROM: data one cycle after the strobe
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr[5:0]];
    end

    // stand-in CUT: an arbitrary combinational fold of its inputs
    function automatic logic [OW-1:0] cut_fn(input logic [VW-1:0] v);
        return v[6:0] ^ v[13:7] ^ v[20:14] ^ v[27:21] ^ v[34:28] ^ {v[35], v[35:30]};
    endfunction

    assign cut_out = cut_mode ? cut_fn(cut_in) : cut_force;

    function automatic logic [OW-1:0] exp_data(input int i);
        return cut_mode ? cut_fn(mem[i]) : cut_force;
    endfunction

    function automatic logic [GW-1:0] sig_model(input int n);
        int s = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            s = ((s * 2) % 65536) ^ ((s >= 32768) ? 16'h1021 : 0) ^ int'(exp_data(i));
        end
        return GW'(s);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 64; i++) mem[i] = {4'($urandom), 32'($urandom)};
    endtask

    // driver + scoreboard for one complete run; k counts edges from the start-sampling edge
    task automatic run_vectors(input int n, input int s, input int poke_at);
        int p = 3 + s;
        int fetch_i = 0;
        int cap_i = 0;
        bit seen_done = 1'b0;
        int budget = n * p + 10;
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(exp_data(i));
        @(negedge clk);
        vec_count = AW'(n);
        settle_cycles = SW'(s);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1'b1);
        for (int k = 1; k <= budget && !seen_done; k++) begin
            if (k > 1) @(negedge clk);
            if (k == poke_at) begin
                start = 1'b1;
                vec_count = AW'(n + 3);
            end else if (k == poke_at + 1) begin
                start = 1'b0;
            end
            if (mem_rd_en) begin
                chk("fetch_addr", mem_addr, fetch_i);
                chk("fetch_time", k, fetch_i * p + 1);
                fetch_i++;
            end
            if (cap_valid) begin
                chk("cap_idx", cap_idx, cap_i);
                if (exp_q.size() == 0) chk("cap_extra", cap_valid, 1'b0);
                else chk("cap_data", cap_data, exp_q.pop_front());
                chk("cap_time", k, (cap_i + 1) * p + 1);
                cap_i++;
            end
            if (done) begin
                seen_done = 1'b1;
                chk("done_time", k, (n == 0) ? 1 : n * p + 1);
                chk("fetch_count", fetch_i, n);
                chk("cap_count", cap_i, n);
                chk("signature", signature, sig_model(n));
            end
        end
        chk("done_seen", seen_done, 1'b1);
        @(negedge clk);
        chk("idle_after_done", {busy, done, cap_valid}, 3'b000);
        if (n > 0) chk("cut_in_hold", cut_in, mem[n - 1]);
    endtask

    initial begin
        logic [GW-1:0] sig_frozen;

        fill_mem();
        repeat (3) @(negedge clk);
        chk("rst_busy_done", {busy, done, cap_valid, mem_rd_en}, 4'b0000);
        chk("rst_signature", signature, 16'hFFFF);
        chk("rst_cut_in", cut_in, '0);
        rst_n = 1'b1;

        // single vector, zero settle, forced CUT outputs
        cut_mode = 1'b0;
        cut_force = 7'h00;
        run_vectors(1, 0, 0);
        chk("sig_const_00", signature, 16'hEFDF);
        cut_force = 7'h7F;
        run_vectors(1, 0, 0);
        chk("sig_const_7f", signature, 16'hEFA0);

        // eight vectors, settle 5, with a start pulse while busy
        cut_mode = 1'b1;
        fill_mem();
        run_vectors(8, 5, 10);

        run_vectors(0, 0, 0);
        chk("sig_empty_run", signature, 16'hFFFF);

        for (int r = 0; r < 4; r++) begin
            fill_mem();
            run_vectors($urandom_range(1, 6), $urandom_range(0, 4), 0);
        end

        // abort during SETTLE of vector 3 (k=27..31)
        fill_mem();
        @(negedge clk);
        vec_count = 16'd8;
        settle_cycles = 8'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (27) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle", {busy, done}, 2'b00);
        chk("abort_cut_in", cut_in, mem[3]);
        chk("abort_signature", signature, sig_model(3));
        chk("abort_cap_idx", cap_idx, 2);
        sig_frozen = sig_model(3);
        begin
            int stray = 0;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                if (done || cap_valid || busy) stray++;
            end
            chk("abort_quiet", stray, 0);
        end
        chk("abort_sig_held", signature, sig_frozen);

        // abort and start together in IDLE
        abort = 1'b1;
        start = 1'b1;
        vec_count = 16'd4;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk("abort_start_idle", busy, 1'b0);
        chk("abort_start_sig", signature, sig_frozen);

        // reset mid-run
        fill_mem();
        vec_count = 16'd4;
        settle_cycles = 8'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_flags", {busy, done, cap_valid, mem_rd_en}, 4'b0000);
        chk("midrst_addr_idx", {mem_addr, cap_idx}, '0);
        chk("midrst_cut_in", cut_in, '0);
        chk("midrst_cap_data", cap_data, '0);
        chk("midrst_signature", signature, 16'hFFFF);
        @(negedge clk);
        rst_n = 1'b1;

        fill_mem();
        run_vectors(3, 1, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
